age_stamp_alloc: RTL and testbench

Slot allocator and age tracker that produces the valid vector and per-slot age operands consumed by the oldest-first choosers. Each entry gets a slot and an age stamp on allocation. Ages are compacted on every free, so valid ages always form the dense set 0..cnt-1, with 0 the oldest. Smaller age means higher priority, and no two valid slots ever share an age. The block sits in front of the issue-select stage: the chooser's grant, once it is issued, comes back here as `free_vld`.

---
 rtl/age_stamp_alloc.sv | 139 +++++++++++++
 tb/tb_age_stamp_alloc.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/age_stamp_alloc.sv
// rtl/age_stamp_alloc.sv - slot allocator with dense oldest-first age stamps
//
// Purpose:
//   Hands out slots to incoming entries and keeps a per-slot age in which
//   0 is the oldest. Valid ages always form the dense set 0..cnt-1, so
//   every free compacts the ages of the younger survivors. The valid vector
//   and ages feed the oldest-first choosers. Their issued grants come back
//   here as free strobes.
//
// Ports:
//   clk, rst_n   clock (rising edge) and asynchronous active-low reset
//   alloc_vld    allocation request
//   alloc_data   payload written into the allocated slot
//   alloc_rdy    a slot is empty and no flush is in progress (combinational)
//   alloc_oh     one-hot lowest empty slot, or 0 when full (combinational)
//   free_vld     per-slot free strobes; any number of bits may be set
//   flush        synchronous clear of all slots; highest priority
//   slot_vld     registered slot valid vector
//   slot_age     registered per-slot age (don't-care when the slot is invalid)
//   slot_data    registered per-slot payload (don't-care when the slot is invalid)
//   cnt          registered number of valid slots
//   err          sticky flag: a free strobe hit an empty slot

module age_stamp_alloc #(
  parameter int NUM   = 3,
  parameter int AGE_W = 5,
  parameter int DW    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             alloc_vld,
  input  logic [DW-1:0]    alloc_data,
  output logic             alloc_rdy,
  output logic [NUM-1:0]   alloc_oh,
  input  logic [NUM-1:0]   free_vld,
  input  logic             flush,
  output logic [NUM-1:0]   slot_vld,
  output logic [AGE_W-1:0] slot_age  [NUM],
  output logic [DW-1:0]    slot_data [NUM],
  output logic [AGE_W-1:0] cnt,
  output logic             err
);

  logic [NUM-1:0]   empty;
  logic [NUM-1:0]   free_eff;
  logic [NUM-1:0]   surv;
  logic             accept;
  logic             stray;
  logic [AGE_W-1:0] surv_cnt;
  logic [AGE_W-1:0] age_nxt [NUM];

  // The target comes from registered state only. A slot freed this cycle
  // becomes a target next cycle at the earliest.
  assign empty = ~slot_vld;

  // The loop runs downward, so the lowest-index empty slot wins.
  always_comb begin
    alloc_oh = '0;
    for (int i = NUM - 1; i >= 0; i--) begin
      if (empty[i]) begin
        alloc_oh    = '0;
        alloc_oh[i] = 1'b1;
      end
    end
  end

  // When the block is full, frees in the same cycle do not open a slot.
  assign alloc_rdy = (|empty) & ~flush;
  assign accept    = alloc_vld & alloc_rdy;

  // Strobes aimed at empty slots are masked out and reported through err.
  assign free_eff = free_vld & slot_vld;
  assign surv     = slot_vld & ~free_eff;
  assign stray    = |(free_vld & ~slot_vld);

  always_comb begin
    surv_cnt = '0;
    for (int i = 0; i < NUM; i++) begin
      if (surv[i]) surv_cnt = surv_cnt + AGE_W'(1);
    end
  end

  // A survivor moves up one step for each freed entry that is older than it.
  // Ages are unique, so this keeps the set dense.
  always_comb begin
    for (int i = 0; i < NUM; i++) begin
      age_nxt[i] = slot_age[i];
      for (int j = 0; j < NUM; j++) begin
        if (free_eff[j] && (slot_age[j] < slot_age[i])) begin
          age_nxt[i] = age_nxt[i] - AGE_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_vld <= '0;
      cnt      <= '0;
    end else if (flush) begin
      slot_vld <= '0;
      cnt      <= '0;
    end else begin
      slot_vld <= surv | (accept ? alloc_oh : '0);
      cnt      <= surv_cnt + AGE_W'(accept);
    end
  end

  // Ages and payloads of freed or flushed slots hold their last values.
  // Only survivors and the new entry are written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM; i++) begin
        slot_age[i]  <= '0;
        slot_data[i] <= '0;
      end
    end else if (!flush) begin
      for (int i = 0; i < NUM; i++) begin
        if (accept && alloc_oh[i]) begin
          // The new entry counts survivors only, so it is always the youngest.
          slot_age[i]  <= surv_cnt;
          slot_data[i] <= alloc_data;
        end else if (surv[i]) begin
          slot_age[i]  <= age_nxt[i];
        end
      end
    end
  end

  // err is sticky. Only reset clears it; flush does not.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (!flush && stray) begin
      err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_age_stamp_alloc.sv
// tb/tb_age_stamp_alloc.sv - self-checking bench for age_stamp_alloc

module tb_age_stamp_alloc;

  localparam int NUM   = 3;
  localparam int AGE_W = 5;
  localparam int DW    = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             alloc_vld;
  logic [DW-1:0]    alloc_data;
  logic             alloc_rdy;
  logic [NUM-1:0]   alloc_oh;
  logic [NUM-1:0]   free_vld;
  logic             flush;
  logic [NUM-1:0]   slot_vld;
  logic [AGE_W-1:0] slot_age  [NUM];
  logic [DW-1:0]    slot_data [NUM];
  logic [AGE_W-1:0] cnt;
  logic             err;

  age_stamp_alloc #(.NUM(NUM), .AGE_W(AGE_W), .DW(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .alloc_vld  (alloc_vld),
    .alloc_data (alloc_data),
    .alloc_rdy  (alloc_rdy),
    .alloc_oh   (alloc_oh),
    .free_vld   (free_vld),
    .flush      (flush),
    .slot_vld   (slot_vld),
    .slot_age   (slot_age),
    .slot_data  (slot_data),
    .cnt        (cnt),
    .err        (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: valid slots kept as a list in arrival order.
  // A slot's age is its position in the list.
  int          order [$];
  logic [7:0]  m_data [NUM];
  logic        m_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit in_order(input int s);
    foreach (order[k]) if (order[k] == s) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    order.delete();
    m_err = 1'b0;
    for (int s = 0; s < NUM; s++) m_data[s] = '0;
  endtask

  task automatic check_regs(input string tag);
    logic [NUM-1:0] exp_vld;
    logic [NUM-1:0] seen;
    bit             perm_ok;
    int             pop;
    exp_vld = '0;
    foreach (order[k]) exp_vld[order[k]] = 1'b1;
    chk({tag, ".slot_vld"}, 32'(slot_vld), 32'(exp_vld));
    chk({tag, ".cnt"}, 32'(cnt), 32'(order.size()));
    chk({tag, ".err"}, 32'(err), 32'(m_err));
    foreach (order[k]) begin
      chk($sformatf("%s.age%0d", tag, order[k]), 32'(slot_age[order[k]]), 32'(k));
      chk($sformatf("%s.data%0d", tag, order[k]), 32'(slot_data[order[k]]), 32'(m_data[order[k]]));
    end
    // The ages of valid slots form a permutation of 0..cnt-1,
    // and cnt equals the number of valid slots.
    seen = '0;
    perm_ok = 1'b1;
    pop = 0;
    for (int s = 0; s < NUM; s++) begin
      if (slot_vld[s]) begin
        pop++;
        if (int'(slot_age[s]) >= int'(cnt) || int'(slot_age[s]) >= NUM) perm_ok = 1'b0;
        else if (seen[slot_age[s]]) perm_ok = 1'b0;
        else seen[slot_age[s]] = 1'b1;
      end
    end
    if (pop != int'(cnt)) perm_ok = 1'b0;
    chk({tag, ".invariant"}, 32'(perm_ok), 32'd1);
  endtask

  task automatic step(input string tag, input logic av, input logic [7:0] ad,
                      input logic [NUM-1:0] fv, input logic fl);
    int             tgt;
    int             keep [$];
    logic [NUM-1:0] exp_oh;
    logic           exp_rdy;
    alloc_vld  = av;
    alloc_data = ad;
    free_vld   = fv;
    flush      = fl;
    #1;
    tgt = -1;
    for (int s = 0; s < NUM; s++) if (tgt < 0 && !in_order(s)) tgt = s;
    exp_oh = '0;
    if (tgt >= 0) exp_oh[tgt] = 1'b1;
    exp_rdy = (tgt >= 0) && !fl;
    chk({tag, ".alloc_oh"}, 32'(alloc_oh), 32'(exp_oh));
    chk({tag, ".alloc_rdy"}, 32'(alloc_rdy), 32'(exp_rdy));
    if (fl) begin
      order.delete();
    end else begin
      for (int s = 0; s < NUM; s++) if (fv[s] && !in_order(s)) m_err = 1'b1;
      keep = {};
      foreach (order[k]) if (!fv[order[k]]) keep.push_back(order[k]);
      order = keep;
      if (av && exp_rdy) begin
        order.push_back(tgt);
        m_data[tgt] = ad;
      end
    end
    @(posedge clk);
    #1;
    check_regs(tag);
  endtask

  initial begin
    logic [NUM-1:0] vmask;
    logic [NUM-1:0] fv;
    rst_n      = 1'b0;
    alloc_vld  = 1'b0;
    alloc_data = '0;
    free_vld   = '0;
    flush      = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;

    // Reset state
    chk("rst.slot_vld", 32'(slot_vld), 32'd0);
    chk("rst.cnt", 32'(cnt), 32'd0);
    chk("rst.err", 32'(err), 32'd0);
    chk("rst.alloc_rdy", 32'(alloc_rdy), 32'd1);
    chk("rst.alloc_oh", 32'(alloc_oh), 32'b001);
    for (int s = 0; s < NUM; s++) begin
      chk($sformatf("rst.age%0d", s), 32'(slot_age[s]), 32'd0);
      chk($sformatf("rst.data%0d", s), 32'(slot_data[s]), 32'd0);
    end

    // Fill
    step("fill0", 1'b1, 8'hA1, 3'b000, 1'b0);
    step("fill1", 1'b1, 8'hA2, 3'b000, 1'b0);
    step("fill2", 1'b1, 8'hA3, 3'b000, 1'b0);
    chk("fill.age2", 32'(slot_age[2]), 32'd2);
    chk("fill.cnt", 32'(cnt), 32'd3);
    chk("fill.alloc_rdy", 32'(alloc_rdy), 32'd0);
    // The fourth request is held while full, including through the free cycle.
    step("held", 1'b1, 8'hB4, 3'b000, 1'b0);
    step("held_free", 1'b1, 8'hB4, 3'b010, 1'b0);
    chk("compact.age0", 32'(slot_age[0]), 32'd0);
    chk("compact.age2", 32'(slot_age[2]), 32'd1);
    chk("compact.cnt", 32'(cnt), 32'd2);
    step("alloc_b4", 1'b1, 8'hB4, 3'b000, 1'b0);
    chk("b4.age1", 32'(slot_age[1]), 32'd2);
    chk("b4.data1", 32'(slot_data[1]), 32'hB4);

    // Simultaneous alloc and free
    step("free1", 1'b0, 8'h00, 3'b010, 1'b0);
    step("alloc_free", 1'b1, 8'hC5, 3'b001, 1'b0);
    chk("af.age2", 32'(slot_age[2]), 32'd0);
    chk("af.age1", 32'(slot_age[1]), 32'd1);
    chk("af.data1", 32'(slot_data[1]), 32'hC5);
    chk("af.cnt", 32'(cnt), 32'd2);

    // Multi-free from the full state with ages 2,0,1
    step("clear", 1'b0, 8'h00, 3'b110, 1'b0);
    step("refill0", 1'b1, 8'hD1, 3'b000, 1'b0);
    step("refill1", 1'b1, 8'hD2, 3'b000, 1'b0);
    step("refill2", 1'b1, 8'hD3, 3'b000, 1'b0);
    step("drop0", 1'b0, 8'h00, 3'b001, 1'b0);
    step("readd0", 1'b1, 8'hD4, 3'b000, 1'b0);
    chk("mf.pre_age0", 32'(slot_age[0]), 32'd2);
    step("multi_free", 1'b0, 8'h00, 3'b110, 1'b0);
    chk("mf.age0", 32'(slot_age[0]), 32'd0);
    chk("mf.cnt", 32'(cnt), 32'd1);

    // Error and flush
    step("stray", 1'b0, 8'h00, 3'b100, 1'b0);
    chk("stray.err", 32'(err), 32'd1);
    chk("stray.vld", 32'(slot_vld), 32'b001);
    step("flush", 1'b1, 8'hEE, 3'b001, 1'b1);
    chk("flush.vld", 32'(slot_vld), 32'd0);
    chk("flush.cnt", 32'(cnt), 32'd0);
    chk("flush.err", 32'(err), 32'd1);

    // Start the random phase from a clean reset.
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst2.err", 32'(err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Random traffic: mostly legal frees, rare stray bits and flushes.
    for (int n = 0; n < 400; n++) begin
      vmask = '0;
      foreach (order[k]) vmask[order[k]] = 1'b1;
      fv = NUM'($urandom);
      if ($urandom_range(0, 31) != 0) fv = fv & vmask;
      if ($urandom_range(0, 2) != 0) fv = '0;
      step($sformatf("rnd%0d", n), 1'($urandom_range(0, 3) != 0), 8'($urandom),
           fv, 1'($urandom_range(0, 40) == 0));
    end

    // Asynchronous reset in the middle of a cycle clears state at once.
    step("pre_arst0", 1'b1, 8'h5A, 3'b000, 1'b0);
    step("pre_arst1", 1'b1, 8'h5B, 3'b000, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst.slot_vld", 32'(slot_vld), 32'd0);
    chk("arst.cnt", 32'(cnt), 32'd0);
    chk("arst.err", 32'(err), 32'd0);
    chk("arst.data0", 32'(slot_data[0]), 32'd0);
    chk("arst.age1", 32'(slot_age[1]), 32'd0);
    alloc_vld = 1'b0;
    free_vld  = '0;
    flush     = 1'b0;
    #1;
    chk("arst.alloc_rdy", 32'(alloc_rdy), 32'd1);
    chk("arst.alloc_oh", 32'(alloc_oh), 32'b001);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step("post_arst", 1'b1, 8'h77, 3'b000, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
